// File: rtl/cmd_assembler.sv
`default_nettype none
// ============================================================================
// Module      : cmd_assembler
// Description : Pairs UART receiver bytes (high byte first) into 16-bit
//               commands, with inter-byte timeout and overrun reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_assembler #(
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        tmo,
  output logic        ovr
);

  localparam logic [19:0] c_tmr_last = 20'(TIMEOUT_CYC - 1);

  typedef enum logic [0:0] {
    ST_HIGH = 1'b0,
    ST_LOW  = 1'b1
  } state_t;

  state_t      r_state;
  logic [7:0]  r_hi_byte;
  logic [19:0] r_tmr;
  logic [15:0] r_cmd;
  logic        r_cmd_rdy;
  logic        r_tmo;
  logic        r_ovr;

  // The receiver drops rdy on the next edge, so a same-cycle ack is safe.
  assign clr_rx_rdy = rx_rdy;

  assign cmd     = r_cmd;
  assign cmd_rdy = r_cmd_rdy;
  assign tmo     = r_tmo;
  assign ovr     = r_ovr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_HIGH;
      r_hi_byte <= 8'h00;
      r_tmr     <= 20'd0;
      r_cmd     <= 16'h0000;
      r_cmd_rdy <= 1'b0;
      r_tmo     <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_tmo <= 1'b0;
      r_ovr <= 1'b0;
      // A completion below overrides this clear, so a new command stays pending.
      if (clr_cmd_rdy) r_cmd_rdy <= 1'b0;

      case (r_state)
        ST_HIGH: begin
          if (rx_rdy) begin
            r_hi_byte <= rx_data;
            r_tmr     <= 20'd0;
            r_state   <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (rx_rdy) begin
            r_cmd     <= {r_hi_byte, rx_data};
            r_cmd_rdy <= 1'b1;
            r_ovr     <= r_cmd_rdy;
            r_state   <= ST_HIGH;
          end else if (r_tmr == c_tmr_last) begin
            r_hi_byte <= 8'h00;
            r_tmo     <= 1'b1;
            r_state   <= ST_HIGH;
          end else begin
            r_tmr <= r_tmr + 20'd1;
          end
        end
        default: r_state <= ST_HIGH;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmd_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmd_assembler
// Description : Self-checking bench for cmd_assembler (TIMEOUT_CYC = 100).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_assembler;

  localparam int unsigned TMO = 100;

  logic        clk;
  logic        rst_n;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic        clr_cmd_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        tmo;
  logic        ovr;

  int n_cmp  = 0;
  int n_fail = 0;
  int clr_cnt = 0;
  int tmo_cnt = 0;
  int ovr_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_cmd;

  cmd_assembler #(.TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .clr_rx_rdy (clr_rx_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .tmo        (tmo),
    .ovr        (ovr)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Acks are counted at the edge the receiver would see them.
  always @(posedge clk) if (clr_rx_rdy === 1'b1) clr_cnt <= clr_cnt + 1;
  always @(negedge clk) begin
    if (tmo === 1'b1) tmo_cnt <= tmo_cnt + 1;
    if (ovr === 1'b1) ovr_cnt <= ovr_cnt + 1;
  end

  // Called at a falling edge; presents one byte for one cycle, returns at the next falling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_rdy  = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_rdy  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; clr_cmd_rdy = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({cmd, cmd_rdy, tmo, ovr, clr_rx_rdy} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_state: got cmd=%h rdy=%b tmo=%b ovr=%b clr=%b required all zero",
               cmd, cmd_rdy, tmo, ovr, clr_rx_rdy);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int c0;
    c0 = clr_cnt;
    exp_q.push_back(16'hA53C);
    rx_rdy = 1'b1; rx_data = 8'hA5;
    #1;
    n_cmp++;
    if (clr_rx_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_same_cycle: got clr_rx_rdy=%b required 1", clr_rx_rdy);
    end
    @(negedge clk);
    rx_rdy = 1'b0;
    n_cmp++;
    if (cmd_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_half: got cmd_rdy=%b required 0", cmd_rdy);
    end
    send_byte(8'h3C);
    exp_cmd = exp_q.pop_front();
    n_cmp++;
    if (cmd !== exp_cmd || cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_cmd: got cmd=%h rdy=%b required cmd=%h rdy=1", cmd, cmd_rdy, exp_cmd);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (clr_cnt - c0 !== 2) begin
      n_fail++;
      $display("FAIL basic_ack_count: got %0d acks required 2", clr_cnt - c0);
    end
    n_cmp++;
    if (tmo_cnt !== 0 || ovr_cnt !== 0) begin
      n_fail++;
      $display("FAIL basic_flags: got tmo=%0d ovr=%0d pulses required 0/0", tmo_cnt, ovr_cnt);
    end
  endtask

  task automatic test_ack();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    n_cmp++;
    if (cmd_rdy !== 1'b0 || cmd !== 16'hA53C) begin
      n_fail++;
      $display("FAIL ack_clear: got cmd=%h rdy=%b required cmd=a53c rdy=0", cmd, cmd_rdy);
    end
    exp_q.push_back(16'h1234);
    send_byte(8'h12);
    clr_cmd_rdy = 1'b1;
    send_byte(8'h34);
    clr_cmd_rdy = 1'b0;
    exp_cmd = exp_q.pop_front();
    n_cmp++;
    if (cmd !== exp_cmd || cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_set_wins: got cmd=%h rdy=%b required cmd=%h rdy=1", cmd, cmd_rdy, exp_cmd);
    end
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic test_timeout();
    int t0;
    t0 = tmo_cnt;
    send_byte(8'hFF);
    repeat (TMO - 1) @(negedge clk);
    n_cmp++;
    if (tmo !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: got tmo=%b required 0 one cycle before expiry", tmo);
    end
    @(negedge clk);
    n_cmp++;
    if (tmo !== 1'b1 || cmd !== 16'h1234) begin
      n_fail++;
      $display("FAIL timeout_fire: got tmo=%b cmd=%h required tmo=1 cmd=1234", tmo, cmd);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (tmo_cnt - t0 !== 1) begin
      n_fail++;
      $display("FAIL timeout_once: got %0d pulses required 1", tmo_cnt - t0);
    end
    exp_q.push_back(16'h0102);
    send_byte(8'h01);
    send_byte(8'h02);
    exp_cmd = exp_q.pop_front();
    n_cmp++;
    if (cmd !== exp_cmd) begin
      n_fail++;
      $display("FAIL timeout_resync: got cmd=%h required %h", cmd, exp_cmd);
    end
  endtask

  task automatic test_expiry_race();
    int t0;
    t0 = tmo_cnt;
    exp_q.push_back(16'hC3D4);
    send_byte(8'hC3);
    repeat (TMO - 1) @(negedge clk);
    send_byte(8'hD4);
    exp_cmd = exp_q.pop_front();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (cmd !== exp_cmd || tmo_cnt !== t0) begin
      n_fail++;
      $display("FAIL race_in_time: got cmd=%h tmo_pulses=%0d required cmd=%h pulses=0",
               cmd, tmo_cnt - t0, exp_cmd);
    end
    send_byte(8'hE5);
    repeat (TMO) @(negedge clk);
    n_cmp++;
    if (tmo !== 1'b1) begin
      n_fail++;
      $display("FAIL race_late_tmo: got tmo=%b required 1", tmo);
    end
    exp_q.push_back(16'h9ABC);
    send_byte(8'h9A);
    n_cmp++;
    if (cmd !== 16'hC3D4) begin
      n_fail++;
      $display("FAIL race_late_new_hi: got cmd=%h required c3d4", cmd);
    end
    send_byte(8'hBC);
    exp_cmd = exp_q.pop_front();
    n_cmp++;
    if (cmd !== exp_cmd) begin
      n_fail++;
      $display("FAIL race_late_cmd: got cmd=%h required %h", cmd, exp_cmd);
    end
  endtask

  task automatic test_overrun();
    int o0;
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    o0 = ovr_cnt;
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h2222);
    send_byte(8'h11);
    send_byte(8'h11);
    exp_cmd = exp_q.pop_front();
    n_cmp++;
    if (cmd !== exp_cmd || ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_first: got cmd=%h ovr=%b required cmd=%h ovr=0", cmd, ovr, exp_cmd);
    end
    send_byte(8'h22);
    send_byte(8'h22);
    exp_cmd = exp_q.pop_front();
    n_cmp++;
    if (cmd !== exp_cmd || ovr !== 1'b1 || cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_second: got cmd=%h ovr=%b rdy=%b required cmd=%h ovr=1 rdy=1",
               cmd, ovr, cmd_rdy, exp_cmd);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (ovr_cnt - o0 !== 1) begin
      n_fail++;
      $display("FAIL ovr_once: got %0d pulses required 1", ovr_cnt - o0);
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    send_byte(8'h77);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({cmd, cmd_rdy, tmo, ovr, clr_rx_rdy} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got cmd=%h rdy=%b tmo=%b ovr=%b clr=%b required all zero",
               cmd, cmd_rdy, tmo, ovr, clr_rx_rdy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    t0 = tmo_cnt;
    repeat (TMO + 5) @(negedge clk);
    n_cmp++;
    if (tmo_cnt !== t0) begin
      n_fail++;
      $display("FAIL reset_no_tmo: got %0d pulses required 0", tmo_cnt - t0);
    end
    exp_q.push_back(16'h5566);
    send_byte(8'h55);
    send_byte(8'h66);
    exp_cmd = exp_q.pop_front();
    n_cmp++;
    if (cmd !== exp_cmd || cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_recover: got cmd=%h rdy=%b required cmd=%h rdy=1", cmd, cmd_rdy, exp_cmd);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_ack();
    test_timeout();
    test_expiry_race();
    test_overrun();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
